// File: rtl/score_display.sv
// Binary score to 5-digit BCD via iterative double-dabble,
// then multiplexed onto an active-low 7-segment display.
module score_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  output logic [19:0] bcd,
  output logic        conv_done,
  output logic        busy,
  output logic [4:0]  dig_an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [19:0] DIV_M1 = 20'(REFRESH_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] last_q, last_d;
  logic [15:0] sh_q, sh_d;
  logic [19:0] scr_q, scr_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  it_q, it_d;
  logic        done_q, done_d;
  logic [19:0] adj;

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [4:0]  nz, live;
  logic [3:0]  dig;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 5; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (score != last_q) begin
          sh_d    = score;
          last_d  = score;
          scr_d   = '0;
          it_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sh_d} = {adj, sh_q} << 1;
        it_d = it_q + 4'd1;
        if (it_q == 4'd15)
          state_d = DONE;
      end
      DONE: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path reads only the latched result, never the scratch.
  always_comb begin
    nz = '0;
    for (int i = 0; i < 5; i++)
      nz[i] = |bcd_q[4*i +: 4];
    live[4] = nz[4];
    for (int i = 3; i >= 0; i--)
      live[i] = nz[i] | live[i+1];

    cnt_d = cnt_q + 20'd1;
    idx_d = idx_q;
    if (cnt_q >= DIV_M1) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end

    dig  = bcd_q[{idx_d, 2'b00} +: 4];
    an_d = ~(5'b00001 << idx_d);
    if (idx_d != 3'd0 && !live[idx_d])
      seg_d = 7'h7F;
    else
      seg_d = enc(dig);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 5'b11110;
      seg_q   <= 7'h40;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd       = bcd_q;
  assign conv_done = done_q;
  assign busy      = (state_q != IDLE);
  assign dig_an    = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: scoreboard on conv_done,
// directed scan and reset checks with REFRESH_DIV=4.
module tb_score_display;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic [19:0] bcd;
  logic        conv_done;
  logic        busy;
  logic [4:0]  dig_an;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [19:0] exp_q[$];

  score_display #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .score(score),
    .bcd(bcd),
    .conv_done(conv_done),
    .busy(busy),
    .dig_an(dig_an),
    .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: pops one expected bcd per conv_done pulse.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (conv_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL conv_unexpected actual=%0h required=none", bcd);
        end else begin
          e = exp_q.pop_front();
          chk("bcd", bcd, e);
        end
        chk("busy_len", busy_cnt, 17);
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int lim, output int n);
    int target;
    target = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=timeout required=conv_done");
    end
  endtask

  task automatic check_scan(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [6:0] s4);
    logic [6:0] ex [5];
    logic [4:0] prev;
    logic [4:0] an_exp;
    bit found;
    ex[0] = s0; ex[1] = s1; ex[2] = s2; ex[3] = s3; ex[4] = s4;
    found = 0;
    prev = dig_an;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (dig_an == 5'b11110 && prev == 5'b01111) begin
        found = 1;
        break;
      end
      prev = dig_an;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    for (int d = 0; d < 5; d++) begin
      an_exp = ~(5'b00001 << d);
      for (int h = 0; h < 4; h++) begin
        if (!(d == 0 && h == 0)) begin
          @(negedge clk);
          #1;
        end
        chk({tag, "_an"}, 32'(dig_an), 32'(an_exp));
        chk({tag, "_seg"}, 32'(seg), 32'(ex[d]));
      end
    end
    @(negedge clk);
    #1;
    chk({tag, "_wrap"}, 32'(dig_an), 32'h1E);
  endtask

  initial begin
    int n;
    int n2;
    reset = 1'b1;
    score = 16'd0;
    #3 reset = 1'b0;
    #1;
    chk("rst_bcd", bcd, 20'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(conv_done), 0);
    chk("rst_an", 32'(dig_an), 32'h1E);
    chk("rst_seg", 32'(seg), 32'h40);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Score 0 after reset: nothing to convert.
    repeat (25) @(negedge clk);
    #1;
    chk("idle_done", done_cnt, 0);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_bcd", bcd, 20'h0);
    check_scan("zero", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // 12345: conv_done seen on the 18th negedge after the change.
    @(negedge clk);
    #1;
    score = 16'd12345;
    exp_q.push_back(20'h12345);
    wait_done(40, n);
    chk("lat_12345", n, 18);
    @(negedge clk);
    #1;
    chk("pulse_12345", 32'(conv_done), 0);
    chk("busy_12345", 32'(busy), 0);

    score = 16'd65535;
    exp_q.push_back(20'h65535);
    wait_done(40, n);
    check_scan("s65535", 7'h12, 7'h30, 7'h12, 7'h12, 7'h02);

    score = 16'd40;
    exp_q.push_back(20'h00040);
    wait_done(40, n);
    check_scan("s40", 7'h40, 7'h19, 7'h7F, 7'h7F, 7'h7F);

    score = 16'd7;
    exp_q.push_back(20'h00007);
    wait_done(40, n);
    check_scan("s7", 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Change while busy: both values must come out, 18 cycles apart.
    score = 16'd100;
    exp_q.push_back(20'h00100);
    exp_q.push_back(20'h00200);
    repeat (5) @(negedge clk);
    #1;
    score = 16'd200;
    wait_done(40, n);
    wait_done(40, n2);
    chk("gap_100_200", n2, 18);

    // Reset in the middle of converting 999.
    score = 16'd999;
    repeat (9) @(negedge clk);
    #1;
    chk("mid_busy", 32'(busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_bcd", bcd, 20'h0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(conv_done), 0);
    chk("mr_an", 32'(dig_an), 32'h1E);
    chk("mr_seg", 32'(seg), 32'h40);
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back(20'h00999);
    reset = 1'b1;
    wait_done(40, n);
    check_scan("s999", 7'h10, 7'h10, 7'h10, 7'h7F, 7'h7F);

    repeat (25) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumes the 16-bit binary game score produced by the score counter and renders it on a 5-digit multiplexed 7-segment display.
- Detects score changes and converts the new value to 5 BCD digits with an iterative 16-cycle double-dabble engine.
- Latches the result and time-multiplexes the digits with leading-zero blanking.
- Sits between the scoring logic and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays selected before the scan advances (legal range 2..2^20-1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- score  input  16  binary score from the score counter; may change on any cycle
- bcd  output  20  latched BCD result, {d4,d3,d2,d1,d0}, with d0 the units digit
- conv_done  output  1  one-cycle pulse when bcd updates
- busy  output  1  high while a conversion is in progress
- dig_an  output  5  digit enables, active-low one-hot; bit i selects digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:

Reset (reset=0, async):
- state=IDLE, last_score=0, bcd=0, conv_done=0, busy=0.
- Scan counter=0, digit index=0, dig_an=5'b11110, seg=7'h40 (shows "0").

FSM states:
- IDLE:
  - On a clock edge with score != last_score: capture score into the shift register, set last_score<=score, clear the 20-bit scratch, load iteration count 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, add 3 to every scratch nibble >=5, then shift {scratch, shiftreg} left by 1.
  - After the 16th shift, go to DONE.
- DONE:
  - bcd<=scratch, conv_done=1 for this cycle only, return to IDLE.

Latency and busy:
- Capture edge E0, shifts on E1..E16, bcd and conv_done valid after E17.
- busy=1 whenever state != IDLE, i.e. from after E0 through E17.
- Back-to-back changes: the minimum spacing between conversions is 18 cycles.

Score changing during conversion:
- Ignored while busy.
- On return to IDLE, score is compared against last_score (the value captured at E0). Any difference starts a new conversion, so bcd always converges to the final stable score.
- No intermediate value is ever lost in a way that leaves bcd stale.

Arithmetic:
- Input range 0..65535 maps to bcd 0x00000..0x65535.
- Nibble corrections are 4-bit; no overflow is possible for 16-bit input.

Scan:
- A 20-bit counter increments every cycle. When it reaches REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->4->0.
- dig_an[idx]=0, all other bits 1.
- seg is registered, updated together with dig_an, and always driven from the latched bcd, never from scratch.

Segment encoding, d=0..9:
- 7'h40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
- Nibble values >9 cannot occur; encode them as blank (7'h7F).

Leading-zero blanking:
- Digit i (i>=1) outputs seg=7'h7F if digits i..4 are all zero.
- Digit 0 is never blanked.

Reset mid-conversion:
- Aborts immediately to reset values.
- After release, a nonzero score triggers a fresh conversion.

Test Plan:
- Reset release with score=0 -> no conversion (busy stays 0), bcd=0x00000, digit 0 seg=7'h40, digits 1-4 seg=7'h7F.
- score=12345 applied at E0 -> busy=1 for 17 cycles, conv_done pulse after E17, bcd=0x12345, then busy=0.
- score=65535 -> bcd=0x65535; with REFRESH_DIV=4, the scan shows seg 7'h12, 7'h30, 7'h12, 7'h12, 7'h02 on dig_an 11110, 11101, 11011, 10111, 01111, each held 4 cycles, then wraps to digit 0.
- score=40 -> bcd=0x00040; digit 0 =7'h40, digit 1 =7'h19, digits 2-4 =7'h7F. Then score=7: digit 1 becomes blank (7'h7F) and digit 0 =7'h78.
- score 100 -> 200 changed 5 cycles into the conversion -> first conv_done with bcd=0x00100, then automatic second conversion, second conv_done with bcd=0x00200, 18 cycles after the first.
- Assert reset at SHIFT iteration 8 of score=999 -> outputs return to reset values asynchronously. After release with score=999, conversion restarts and yields bcd=0x00999.
